float_narrow: RTL and testbench
===============================

Name: float_narrow

Overview:
- Parametrised IEEE-754 narrowing converter: wide binary float in, narrower binary float out.
- Successor to the fixed double-to-single converter. Adds:
  - configurable formats;
  - four run-time rounding modes;
  - correct round-to-nearest-even, including mantissa carry into the exponent;
  - gradual underflow to subnormals;
  - exception flags.
- Sits on the same stb/ack streaming bus as the other converters in the FPU library.

Parameters:
- IN_EXP, 11, input exponent width; must be > OUT_EXP.
- IN_MAN, 52, input fraction width; must be >= OUT_MAN+3.
- OUT_EXP, 8, output exponent width.
- OUT_MAN, 23, output fraction width.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- input_a  input  IN_EXP+IN_MAN+1  operand {sign, exponent, fraction}.
- input_rm  input  2  rounding mode, sampled with input_a: 0=RNE, 1=RTZ, 2=RUP (toward +inf), 3=RDN (toward -inf).
- input_a_stb  input  1  operand valid.
- input_a_ack  output  1  operand accepted.
- output_z  output  OUT_EXP+OUT_MAN+1  result.
- output_flags  output  4  {invalid, overflow, underflow, inexact}; valid with output_z.
- output_z_stb  output  1  result valid.
- output_z_ack  input  1  result consumed.

Behaviour:
- Reset (rst low, asynchronous):
  - state=get_a; input_a_ack=0, output_z_stb=0, output_z=0, output_flags=0.
  - An in-flight transaction is discarded.
  - input_a_ack rises on the first clk edge after rst is released.
- States: get_a -> unpack -> [denormalise]* -> round -> pack -> put_z -> get_a.
- get_a:
  - input_a_ack=1. On an edge with ack && stb: latch input_a and input_rm, drop ack, go to unpack.
- unpack:
  - Rebiased exponent e = a_e - (2^(IN_EXP-1)-1) + (2^(OUT_EXP-1)-1), computed signed, width IN_EXP+2.
  - m = {1, top OUT_MAN input fraction bits}. guard/round = next two bits; sticky = OR of the remaining bits.
- Special cases in unpack (all go directly to pack):
  - a_e all ones, fraction 0: ±inf, flags 0.
  - a_e all ones, fraction nonzero: quiet NaN.
    - Sign preserved; fraction MSB=1.
    - Lower OUT_MAN-1 fraction bits = next input fraction bits.
    - invalid=1 iff input fraction MSB=0 (sNaN).
  - a_e=0, fraction 0: ±0, flags 0.
  - a_e=0, fraction nonzero: treated as nonzero value below the smallest output subnormal.
    - RTZ, RNE, and opposite-direction modes give ±0.
    - RUP on positive or RDN on negative gives ±min subnormal (fraction 1).
    - underflow=inexact=1.
- Underflow path: if e <= 0, go to denormalise. Otherwise go to round.
- denormalise, one bit per cycle:
  - m >>= 1; guard <= m[0]; round <= guard; sticky |= round; e += 1.
  - Exit to round when e == 1, or when m == 0 and guard == 0 with sticky already captured.
  - Maximum OUT_MAN+2 cycles.
  - Tininess is detected before rounding: underflow=1 iff the value entered denormalise and the result is inexact.
- round:
  - inexact = guard|round|sticky.
  - Increment condition by mode:
    - RNE: guard && (round || sticky || m[0]).
    - RTZ: never.
    - RUP: inexact && !sign.
    - RDN: inexact && sign.
  - Increment is OUT_MAN+2 wide.
  - Carry out of the mantissa: m = 1.0, e += 1.
  - Subnormal m whose hidden bit becomes 1 is promoted to the minimum normal (exponent field 1).
- pack:
  - If e >= 2^OUT_EXP-1 after rounding, overflow=inexact=1. Result:
    - RNE: ±inf.
    - RTZ: ±max finite.
    - RUP: +inf if positive, -max finite if negative.
    - RDN: +max finite if positive, -inf if negative.
  - Exponent field = 0 if the hidden bit is 0, otherwise e.
- put_z:
  - output_z_stb=1 with output_z and output_flags stable.
  - On an edge with stb && output_z_ack: stb=0, go to get_a.
  - Output is held indefinitely under backpressure.
- Latency (normal path): operand handshake at edge T gives output_z_stb high after edge T+4. Each denormalise cycle adds 1.
- No pipelining: one operand in flight.
- input_a_ack is low from the accepting edge until one edge after the output handshake.

Test Plan (default parameters):
- 0x3FF0000000000000, RNE -> 0x3F800000, flags 0000; stb exactly 4 edges after accept. Hold output_z_ack low 10 cycles -> output stable, input_a_ack stays low.
- Rounding, 0x3FF0000030000000:
  - RNE -> 0x3F800002, inexact.
  - RTZ -> 0x3F800001, inexact.
  - 0x3FF0000010000000 with RNE (tie, even LSB) -> 0x3F800000, inexact.
  - 0x3FFFFFFFF0000000 with RNE -> carry to 0x40000000, inexact.
- Overflow, 0x47F0000000000000 (2^128):
  - RNE -> 0x7F800000.
  - RTZ -> 0x7F7FFFFF.
  - RDN -> 0x7F7FFFFF.
  - Sign-flipped input with RUP -> 0xFF7FFFFF.
  - All cases: flags overflow+inexact.
- Subnormals:
  - 0x36A0000000000000 (2^-149) -> 0x00000001, flags 0.
  - 0x3690000000000000 (2^-150): RNE -> 0x00000000, underflow+inexact; RUP -> 0x00000001, underflow+inexact.
  - Check stb latency grows by the number of denormalise cycles.
- Specials:
  - 0x7FF0000000000001 -> 0x7FC00000, invalid.
  - 0xFFF8000000000000 -> 0xFFC00000, flags 0.
  - 0xFFF0000000000000 -> 0xFF800000.
  - 0x0000000000000001 with RUP -> 0x00000001, underflow+inexact.
- Reset and reconfiguration:
  - Assert rst low during denormalise -> stb/ack drop immediately, no output. After release, 1.0 converts correctly.
  - Instance with IN_EXP=8, IN_MAN=23, OUT_EXP=5, OUT_MAN=10: 0x3F800000 -> 0x3C00; 0x47800000 (65536), RNE -> 0x7C00, overflow+inexact.

Source files
------------

// File: rtl/float_narrow.sv
// float_narrow: IEEE-754 narrowing converter (wide float -> narrow float) on a stb/ack stream.
// One operand in flight; subnormal results come from a bit-serial denormalise loop before rounding.
module float_narrow #(
  parameter int IN_EXP  = 11,
  parameter int IN_MAN  = 52,
  parameter int OUT_EXP = 8,
  parameter int OUT_MAN = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IN_EXP+IN_MAN:0]   input_a,
  input  logic [1:0]               input_rm,
  input  logic                     input_a_stb,
  output logic                     input_a_ack,
  output logic [OUT_EXP+OUT_MAN:0] output_z,
  output logic [3:0]               output_flags,
  output logic                     output_z_stb,
  input  logic                     output_z_ack
);
  localparam int EW       = IN_EXP + 2;
  localparam int IN_BIAS  = (1 << (IN_EXP-1)) - 1;
  localparam int OUT_BIAS = (1 << (OUT_EXP-1)) - 1;
  localparam logic [EW-1:0]        BIAS_ADJ = EW'(OUT_BIAS - IN_BIAS);
  localparam logic signed [EW-1:0] EMAX     = EW'((1 << OUT_EXP) - 1);
  localparam logic [1:0] RNE = 2'd0, RTZ = 2'd1, RUP = 2'd2, RDN = 2'd3;

  typedef enum logic [2:0] {GET_A, UNPACK, DENORM, ROUND, PACK, PUT_Z} state_t;

  state_t                   state_q, state_d;
  logic                     ack_q, ack_d, zstb_q, zstb_d;
  logic [OUT_EXP+OUT_MAN:0] z_q, z_d;
  logic [3:0]               flags_q, flags_d;
  logic [IN_EXP+IN_MAN:0]   a_q, a_d;
  logic [1:0]               rm_q, rm_d;
  logic                     sign_q, sign_d;
  logic signed [EW-1:0]     e_q, e_d;
  logic [OUT_MAN:0]         m_q, m_d;
  logic                     g_q, g_d, r_q, r_d, s_q, s_d;
  logic                     den_q, den_d, inx_q, inx_d, spec_q, spec_d;
  logic                     inc;
  logic [OUT_MAN+1:0]       sum;

  logic                     a_s;
  logic [IN_EXP-1:0]        a_e;
  logic [IN_MAN-1:0]        a_f;
  assign {a_s, a_e, a_f} = a_q;

  assign input_a_ack  = ack_q;
  assign output_z_stb = zstb_q;
  assign output_z     = z_q;
  assign output_flags = flags_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= GET_A;
      ack_q   <= 1'b0;
      zstb_q  <= 1'b0;
      z_q     <= '0;
      flags_q <= '0;
      a_q     <= '0;
      rm_q    <= '0;
      sign_q  <= 1'b0;
      e_q     <= '0;
      m_q     <= '0;
      g_q     <= 1'b0;
      r_q     <= 1'b0;
      s_q     <= 1'b0;
      den_q   <= 1'b0;
      inx_q   <= 1'b0;
      spec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      zstb_q  <= zstb_d;
      z_q     <= z_d;
      flags_q <= flags_d;
      a_q     <= a_d;
      rm_q    <= rm_d;
      sign_q  <= sign_d;
      e_q     <= e_d;
      m_q     <= m_d;
      g_q     <= g_d;
      r_q     <= r_d;
      s_q     <= s_d;
      den_q   <= den_d;
      inx_q   <= inx_d;
      spec_q  <= spec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    zstb_d  = zstb_q;
    z_d     = z_q;
    flags_d = flags_q;
    a_d     = a_q;
    rm_d    = rm_q;
    sign_d  = sign_q;
    e_d     = e_q;
    m_d     = m_q;
    g_d     = g_q;
    r_d     = r_q;
    s_d     = s_q;
    den_d   = den_q;
    inx_d   = inx_q;
    spec_d  = spec_q;
    inc     = 1'b0;
    sum     = '0;
    case (state_q)
      GET_A: begin
        ack_d = 1'b1;
        if (ack_q && input_a_stb) begin
          ack_d   = 1'b0;
          a_d     = input_a;
          rm_d    = input_rm;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        sign_d = a_s;
        e_d    = {2'b00, a_e} + BIAS_ADJ;
        m_d    = {1'b1, a_f[IN_MAN-1 -: OUT_MAN]};
        g_d    = a_f[IN_MAN-OUT_MAN-1];
        r_d    = a_f[IN_MAN-OUT_MAN-2];
        s_d    = |a_f[IN_MAN-OUT_MAN-3:0];
        den_d  = 1'b0;
        spec_d = 1'b0;
        if (&a_e) begin
          spec_d  = 1'b1;
          state_d = PACK;
          if (a_f == '0) begin
            z_d     = {a_s, {OUT_EXP{1'b1}}, {OUT_MAN{1'b0}}};
            flags_d = 4'b0000;
          end else begin
            z_d     = {a_s, {OUT_EXP{1'b1}}, 1'b1, a_f[IN_MAN-2 -: OUT_MAN-1]};
            flags_d = {~a_f[IN_MAN-1], 3'b000};
          end
        end else if (a_e == '0) begin
          spec_d  = 1'b1;
          state_d = PACK;
          if (a_f == '0) begin
            z_d     = {a_s, {(OUT_EXP+OUT_MAN){1'b0}}};
            flags_d = 4'b0000;
          end else begin
            // Input subnormals lie far below the output range: only directed rounding away from zero survives.
            z_d     = {a_s, {(OUT_EXP+OUT_MAN-1){1'b0}},
                       (rm_q == RUP && !a_s) || (rm_q == RDN && a_s)};
            flags_d = 4'b0011;
          end
        end else if (e_d[EW-1] || e_d == '0) begin
          den_d   = 1'b1;
          state_d = DENORM;
        end else begin
          state_d = ROUND;
        end
      end
      DENORM: begin
        m_d = m_q >> 1;
        g_d = m_q[0];
        r_d = g_q;
        s_d = s_q | r_q;
        e_d = e_q + EW'(1);
        // m_q == 0 here means the shifted mantissa and guard are both zero; further shifts only feed sticky.
        if (e_q == '0 || m_q == '0) state_d = ROUND;
      end
      ROUND: begin
        inx_d = g_q | r_q | s_q;
        case (rm_q)
          RNE:     inc = g_q & (r_q | s_q | m_q[0]);
          RUP:     inc = inx_d & ~sign_q;
          RDN:     inc = inx_d & sign_q;
          default: inc = 1'b0;
        endcase
        sum = {1'b0, m_q} + {{(OUT_MAN+1){1'b0}}, inc};
        if (sum[OUT_MAN+1]) begin
          m_d = {1'b1, {OUT_MAN{1'b0}}};
          e_d = e_q + EW'(1);
        end else begin
          m_d = sum[OUT_MAN:0];
        end
        state_d = PACK;
      end
      PACK: begin
        state_d = PUT_Z;
        if (!spec_q) begin
          if (e_q >= EMAX) begin
            flags_d = 4'b0101;
            if (rm_q == RNE || (rm_q == RUP && !sign_q) || (rm_q == RDN && sign_q))
              z_d = {sign_q, {OUT_EXP{1'b1}}, {OUT_MAN{1'b0}}};
            else
              z_d = {sign_q, {(OUT_EXP-1){1'b1}}, 1'b0, {OUT_MAN{1'b1}}};
          end else begin
            z_d     = {sign_q, m_q[OUT_MAN] ? e_q[OUT_EXP-1:0] : {OUT_EXP{1'b0}}, m_q[OUT_MAN-1:0]};
            flags_d = {2'b00, den_q & inx_q, inx_q};
          end
        end
      end
      PUT_Z: begin
        zstb_d = 1'b1;
        if (zstb_q && output_z_ack) begin
          zstb_d  = 1'b0;
          state_d = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end
endmodule

// File: tb/tb_float_narrow.sv
// Directed bench for float_narrow: double->single and single->half instances, queue scoreboard.
module tb_float_narrow;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] a = '0;
  logic [1:0]  rm = '0;
  logic        a_stb = 1'b0, a_ack;
  logic [31:0] z;
  logic [3:0]  fl;
  logic        z_stb, z_ack = 1'b0;

  logic [31:0] sa = '0;
  logic [1:0]  srm = '0;
  logic        sa_stb = 1'b0, sa_ack;
  logic [15:0] sz;
  logic [3:0]  sfl;
  logic        sz_stb, sz_ack = 1'b0;

  float_narrow dut (
    .clk(clk), .rst(rst), .input_a(a), .input_rm(rm), .input_a_stb(a_stb), .input_a_ack(a_ack),
    .output_z(z), .output_flags(fl), .output_z_stb(z_stb), .output_z_ack(z_ack));

  float_narrow #(.IN_EXP(8), .IN_MAN(23), .OUT_EXP(5), .OUT_MAN(10)) sdut (
    .clk(clk), .rst(rst), .input_a(sa), .input_rm(srm), .input_a_stb(sa_stb), .input_a_ack(sa_ack),
    .output_z(sz), .output_flags(sfl), .output_z_stb(sz_stb), .output_z_ack(sz_ack));

  typedef struct packed {
    logic [31:0] z;
    logic [3:0]  f;
    logic [7:0]  lat;
  } exp_t;
  exp_t sb[$];

  int npass = 0, nfail = 0, nchk = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input bit sm, input logic [63:0] op, input logic [1:0] mode,
                      input logic [31:0] ez, input logic [3:0] ef, input int elat,
                      input int hold, input string tag);
    exp_t e, got;
    int k;
    bit ok;
    logic [31:0] zobs;
    e.z = ez; e.f = ef; e.lat = 8'(elat);
    @(negedge clk);
    sb.push_back(e);
    if (sm) begin sa = op[31:0]; srm = mode; sa_stb = 1'b1; end
    else begin a = op; rm = mode; a_stb = 1'b1; end
    k = 0;
    while (!(sm ? sa_ack : a_ack) && k < 50) begin @(posedge clk); #1; k++; end
    check({tag, " accept"}, 64'(sm ? sa_ack : a_ack), 64'd1);
    @(posedge clk); #1;
    a_stb = 1'b0; sa_stb = 1'b0;
    k = 0;
    while (!(sm ? sz_stb : z_stb) && k < 60) begin @(posedge clk); #1; k++; end
    got = sb.pop_front();
    zobs = sm ? {16'h0, sz} : z;
    check({tag, " z"}, 64'(zobs), 64'(got.z));
    check({tag, " flags"}, 64'(sm ? sfl : fl), 64'(got.f));
    check({tag, " latency"}, 64'(k), 64'(got.lat));
    if (hold > 0) begin
      ok = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        if (z !== zobs || z_stb !== 1'b1 || a_ack !== 1'b0) ok = 1'b0;
      end
      check({tag, " hold"}, 64'(ok), 64'd1);
    end
    if (sm) sz_ack = 1'b1; else z_ack = 1'b1;
    @(posedge clk); #1;
    sz_ack = 1'b0; z_ack = 1'b0;
    check({tag, " stb drop"}, 64'(sm ? sz_stb : z_stb), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    check("reset ack", 64'(a_ack), 64'd0);
    check("reset stb", 64'(z_stb), 64'd0);
    check("reset z", 64'(z), 64'd0);
    check("reset flags", 64'(fl), 64'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("ack after release", 64'(a_ack), 64'd1);
    check("small ack after release", 64'(sa_ack), 64'd1);

    xfer(0, 64'h3FF0000000000000, 2'd0, 32'h3F800000, 4'b0000, 4, 10, "one rne");
    xfer(0, 64'h3FF0000030000000, 2'd0, 32'h3F800002, 4'b0001, 4, 0, "rnd up rne");
    xfer(0, 64'h3FF0000030000000, 2'd1, 32'h3F800001, 4'b0001, 4, 0, "rnd rtz");
    xfer(0, 64'h3FF0000010000000, 2'd0, 32'h3F800000, 4'b0001, 4, 0, "tie even");
    xfer(0, 64'h3FFFFFFFF0000000, 2'd0, 32'h40000000, 4'b0001, 4, 0, "man carry");
    xfer(0, 64'h47F0000000000000, 2'd0, 32'h7F800000, 4'b0101, 4, 0, "ovf rne");
    xfer(0, 64'h47F0000000000000, 2'd1, 32'h7F7FFFFF, 4'b0101, 4, 0, "ovf rtz");
    xfer(0, 64'h47F0000000000000, 2'd3, 32'h7F7FFFFF, 4'b0101, 4, 0, "ovf rdn");
    xfer(0, 64'hC7F0000000000000, 2'd2, 32'hFF7FFFFF, 4'b0101, 4, 0, "ovf neg rup");
    xfer(0, 64'h36A0000000000000, 2'd0, 32'h00000001, 4'b0000, 4 + 23, 0, "sub 2^-149");
    xfer(0, 64'h3690000000000000, 2'd0, 32'h00000000, 4'b0011, 4 + 24, 0, "sub 2^-150 rne");
    xfer(0, 64'h3690000000000000, 2'd2, 32'h00000001, 4'b0011, 4 + 24, 0, "sub 2^-150 rup");
    xfer(0, 64'h7FF0000000000001, 2'd0, 32'h7FC00000, 4'b1000, 3, 0, "snan");
    xfer(0, 64'hFFF8000000000000, 2'd0, 32'hFFC00000, 4'b0000, 3, 0, "qnan neg");
    xfer(0, 64'hFFF0000000000000, 2'd0, 32'hFF800000, 4'b0000, 3, 0, "neg inf");
    xfer(0, 64'h0000000000000001, 2'd2, 32'h00000001, 4'b0011, 3, 0, "in sub rup");

    // Abort a transaction partway through its denormalise loop.
    @(negedge clk);
    a = 64'h3690000000000000; rm = 2'd0; a_stb = 1'b1;
    k = 0;
    while (!a_ack && k < 50) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    a_stb = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid rst ack", 64'(a_ack), 64'd0);
    check("mid rst stb", 64'(z_stb), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    seen = 1'b0;
    repeat (30) begin @(posedge clk); #1; if (z_stb !== 1'b0) seen = 1'b1; end
    check("no output after abort", 64'(seen), 64'd0);
    xfer(0, 64'h3FF0000000000000, 2'd0, 32'h3F800000, 4'b0000, 4, 0, "one after rst");

    xfer(1, 64'h3F800000, 2'd0, 32'h00003C00, 4'b0000, 4, 0, "half one");
    xfer(1, 64'h47800000, 2'd0, 32'h00007C00, 4'b0101, 4, 0, "half ovf");

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
